// File: rtl/minterm_extractor_if.sv
// Bundle between the truth-table extractor and the function under test:
// start/s in, row stimulus x,y,z and result busy/done/mask/count out.
interface minterm_extractor_if;
    logic       start;
    logic       s;
    logic       x;
    logic       y;
    logic       z;
    logic       busy;
    logic       done;
    logic [7:0] mask;
    logic [3:0] count;

    modport master (
        input  start,
        input  s,
        output x,
        output y,
        output z,
        output busy,
        output done,
        output mask,
        output count
    );

    modport slave (
        output start,
        output s,
        input  x,
        input  y,
        input  z,
        input  busy,
        input  done,
        input  mask,
        input  count
    );
endinterface

// File: rtl/minterm_extractor.sv
// Sweeps {x,y,z} over rows 0..7, records s per row and reports the minterm mask
// plus its popcount. Optional macro TT_SETTLE_EN adds a SETTLE cycle per row.
module minterm_extractor (
    input  logic                       clk,
    input  logic                       rst_n,
    minterm_extractor_if.master        bus
);

`ifdef TT_SETTLE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd3
    } state_t;
`endif

    state_t     state_r;
    logic [2:0] idx_r;
    logic [7:0] acc_r;
    logic [7:0] mask_r;
    logic [3:0] count_r;
    logic       busy_r;
    logic       done_r;

    logic [7:0] acc_sample_s;
    logic       last_row_s;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Accumulator as it will look once the current row's s has been captured.
    always_comb begin
        acc_sample_s        = acc_r;
        acc_sample_s[idx_r] = bus.s;
        if (idx_r == 3'd7) begin
            last_row_s = 1'b1;
        end else begin
            last_row_s = 1'b0;
        end
    end

    // Sweep controller; idx returns to 0 on entering DONE so x,y,z read 000 there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
            acc_r   <= 8'h00;
            mask_r  <= 8'h00;
            count_r <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= ST_DRIVE;
                        idx_r   <= 3'd0;
                        acc_r   <= 8'h00;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
`ifdef TT_SETTLE_EN
                ST_DRIVE: begin
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    acc_r <= acc_sample_s;
                    if (last_row_s) begin
                        state_r <= ST_DONE;
                        idx_r   <= 3'd0;
                        mask_r  <= acc_sample_s;
                        count_r <= popcount8(acc_sample_s);
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRIVE;
                        idx_r   <= idx_r + 3'd1;
                    end
                end
`else
                ST_DRIVE: begin
                    acc_r <= acc_sample_s;
                    if (last_row_s) begin
                        state_r <= ST_DONE;
                        idx_r   <= 3'd0;
                        mask_r  <= acc_sample_s;
                        count_r <= popcount8(acc_sample_s);
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRIVE;
                        idx_r   <= idx_r + 3'd1;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= 3'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x     = idx_r[2];
    assign bus.y     = idx_r[1];
    assign bus.z     = idx_r[0];
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.mask  = mask_r;
    assign bus.count = count_r;

endmodule

// File: tb/tb_minterm_extractor.sv
// Self-checking bench for minterm_extractor: a truth-table model of the function
// under test drives s, and expected masks/counts come from that table directly.
module tb_minterm_extractor;

`ifdef TT_SETTLE_EN
    localparam int RC = 2;
`else
    localparam int RC = 1;
`endif
    localparam int DONE_AT = 8 * RC;
    localparam int PERIOD  = 8 * RC + 2;

    logic clk;
    logic rst_n;
    minterm_extractor_if bus ();

    minterm_extractor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] fut_tt;
    logic       fut_reg_mode;
    logic       s_reg;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) s_reg <= fut_tt[{bus.x, bus.y, bus.z}];
    assign bus.s = fut_reg_mode ? s_reg : fut_tt[{bus.x, bus.y, bus.z}];

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ref_count(input logic [7:0] tt);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(tt[i]);
        return 4'(n);
    endfunction

    // A one-register function sampled without a settle cycle sees the previous row.
    function automatic logic [7:0] ref_registered(input logic [7:0] tt);
        logic [7:0] m;
`ifdef TT_SETTLE_EN
        m = tt;
`else
        for (int i = 0; i < 8; i++) m[i] = tt[(i == 0) ? 0 : i - 1];
`endif
        return m;
    endfunction

    task automatic run_sweep(input int repulse_at,
                             output logic [7:0] got_mask, output logic [3:0] got_count,
                             output int done_cycle, output int done_pulses,
                             output int seq_err, output int hold_err,
                             output int busy_err, output logic post_idle_ok);
        logic [7:0] held;
        logic [2:0] row;
        held = bus.mask;
        got_mask = 8'h00; got_count = 4'd0;
        done_cycle = -1; done_pulses = 0;
        seq_err = 0; hold_err = 0; busy_err = 0; post_idle_ok = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < DONE_AT + 4; c++) begin
            if (c == repulse_at) bus.start = 1'b1;
            else if (c == repulse_at + 1) bus.start = 1'b0;
            if (c < DONE_AT) begin
                row = 3'(c / RC);
                if ({bus.x, bus.y, bus.z} !== row) seq_err++;
                if (bus.mask !== held) hold_err++;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_err++;
            end
            if (bus.done === 1'b1) begin
                done_pulses++;
                if (done_cycle < 0) begin
                    done_cycle = c;
                    got_mask   = bus.mask;
                    got_count  = bus.count;
                    if (bus.busy !== 1'b1 || {bus.x, bus.y, bus.z} !== 3'b000) busy_err++;
                end
            end
            if (c == DONE_AT + 1) post_idle_ok = (bus.busy === 1'b0 && bus.done === 1'b0);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.start = 1'b0; fut_tt = 8'h00; fut_reg_mode = 1'b0;
        #3;
        checks++; if (bus.mask !== 8'h00 || bus.count !== 4'd0) begin failures++;
            $display("FAIL reset_result got mask=%h count=%0d exp 00/0", bus.mask, bus.count); end
        checks++; if ({bus.busy, bus.done, bus.x, bus.y, bus.z} !== 5'b00000) begin failures++;
            $display("FAIL reset_ctrl got busy,done,xyz=%b exp 00000", {bus.busy, bus.done, bus.x, bus.y, bus.z}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_z_function;
        logic [7:0] m; logic [3:0] n; int dc, dp, se, he, be; logic pi;
        fut_tt = 8'hAA;
        run_sweep(-1, m, n, dc, dp, se, he, be, pi);
        checks++; if (m !== 8'hAA) begin failures++; $display("FAIL z_mask got=%h exp=aa", m); end
        checks++; if (n !== 4'd4) begin failures++; $display("FAIL z_count got=%0d exp=4", n); end
        checks++; if (dc !== DONE_AT) begin failures++; $display("FAIL z_latency got=%0d exp=%0d", dc, DONE_AT); end
        checks++; if (dp !== 1) begin failures++; $display("FAIL z_done_pulses got=%0d exp=1", dp); end
        checks++; if (se !== 0) begin failures++; $display("FAIL z_row_sequence errors=%0d exp=0", se); end
        checks++; if (he !== 0) begin failures++; $display("FAIL z_mask_hold errors=%0d exp=0", he); end
        checks++; if (be !== 0) begin failures++; $display("FAIL z_busy errors=%0d exp=0", be); end
        checks++; if (pi !== 1'b1) begin failures++; $display("FAIL z_return_idle got=%b exp=1", pi); end
    endtask

    task automatic test_constants;
        logic [7:0] m; logic [3:0] n; int dc, dp, se, he, be; logic pi;
        fut_tt = 8'h00;
        run_sweep(-1, m, n, dc, dp, se, he, be, pi);
        checks++; if (m !== 8'h00 || n !== 4'd0) begin failures++;
            $display("FAIL zero_fn got mask=%h count=%0d exp 00/0", m, n); end
        fut_tt = 8'hFF;
        run_sweep(-1, m, n, dc, dp, se, he, be, pi);
        checks++; if (m !== 8'hFF || n !== 4'd8) begin failures++;
            $display("FAIL ones_fn got mask=%h count=%0d exp ff/8", m, n); end
        checks++; if (he !== 0) begin failures++; $display("FAIL ones_mask_hold errors=%0d exp=0", he); end
    endtask

    task automatic test_ignore_start;
        logic [7:0] m; logic [3:0] n; int dc, dp, se, he, be; logic pi; int late_busy;
        fut_tt = 8'h3C;
        run_sweep(3 * RC, m, n, dc, dp, se, he, be, pi);
        checks++; if (dp !== 1 || dc !== DONE_AT) begin failures++;
            $display("FAIL repulse_done got pulses=%0d cycle=%0d exp 1/%0d", dp, dc, DONE_AT); end
        checks++; if (m !== 8'h3C || se !== 0) begin failures++;
            $display("FAIL repulse_mask got=%h seq_err=%0d exp 3c/0", m, se); end
        late_busy = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.busy !== 1'b0) late_busy++;
            @(negedge clk);
        end
        checks++; if (pi !== 1'b1 || late_busy !== 0) begin failures++;
            $display("FAIL repulse_no_queue got idle=%b late_busy=%0d exp 1/0", pi, late_busy); end
    endtask

    task automatic test_reset_mid_sweep;
        logic [7:0] m; logic [3:0] n; int dc, dp, se, he, be; logic pi; int stray;
        fut_tt = 8'hAA;
        run_sweep(-1, m, n, dc, dp, se, he, be, pi);
        checks++; if (m !== 8'hAA) begin failures++; $display("FAIL pre_reset_mask got=%h exp=aa", m); end
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4 * RC) @(negedge clk);
        checks++; if ({bus.x, bus.y, bus.z} !== 3'd4) begin failures++;
            $display("FAIL mid_row got=%0d exp=4", {bus.x, bus.y, bus.z}); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mask !== 8'h00 || bus.count !== 4'd0) begin failures++;
            $display("FAIL mid_reset_result got mask=%h count=%0d exp 00/0", bus.mask, bus.count); end
        checks++; if ({bus.busy, bus.done, bus.x, bus.y, bus.z} !== 5'b00000) begin failures++;
            $display("FAIL mid_reset_ctrl got=%b exp=00000", {bus.busy, bus.done, bus.x, bus.y, bus.z}); end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < DONE_AT + 4; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL mid_reset_stray got=%0d exp=0", stray); end
        fut_tt = 8'hC0;
        run_sweep(-1, m, n, dc, dp, se, he, be, pi);
        checks++; if (m !== 8'hC0 || n !== 4'd2) begin failures++;
            $display("FAIL after_reset_xy got mask=%h count=%0d exp c0/2", m, n); end
    endtask

    task automatic test_random;
        logic [7:0] m; logic [3:0] n; int dc, dp, se, he, be; logic pi; logic [7:0] tt;
        for (int k = 0; k < 6; k++) begin
            tt = 8'($urandom);
            fut_tt = tt;
            run_sweep(-1, m, n, dc, dp, se, he, be, pi);
            checks++; if (m !== tt) begin failures++; $display("FAIL rand_mask got=%h exp=%h", m, tt); end
            checks++; if (n !== ref_count(tt)) begin failures++;
                $display("FAIL rand_count got=%0d exp=%0d", n, ref_count(tt)); end
            checks++; if (dc !== DONE_AT || he !== 0) begin failures++;
                $display("FAIL rand_timing got cycle=%0d hold_err=%0d exp %0d/0", dc, he, DONE_AT); end
        end
    endtask

    task automatic test_back_to_back;
        int dq[$]; logic [7:0] tt;
        tt = 8'($urandom);
        fut_tt = tt;
        bus.start = 1'b1;
        for (int c = 0; c < 2 * PERIOD + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) dq.push_back(c);
        end
        bus.start = 1'b0;
        repeat (PERIOD + 2) @(negedge clk);
        checks++; if (dq.size() < 2) begin failures++; $display("FAIL b2b_count got=%0d exp>=2", dq.size()); end
        else begin
            checks++; if (dq[0] !== DONE_AT || dq[1] - dq[0] !== PERIOD) begin failures++;
                $display("FAIL b2b_spacing got first=%0d gap=%0d exp %0d/%0d", dq[0], dq[1] - dq[0], DONE_AT, PERIOD); end
        end
        checks++; if (bus.mask !== tt || bus.busy !== 1'b0) begin failures++;
            $display("FAIL b2b_final got mask=%h busy=%b exp %h/0", bus.mask, bus.busy, tt); end
    endtask

    task automatic test_registered_fut;
        logic [7:0] m; logic [3:0] n; int dc, dp, se, he, be; logic pi; logic [7:0] exp_m;
        fut_tt = 8'h96;
        fut_reg_mode = 1'b1;
        repeat (2) @(negedge clk);
        exp_m = ref_registered(8'h96);
        run_sweep(-1, m, n, dc, dp, se, he, be, pi);
        checks++; if (m !== exp_m || n !== ref_count(exp_m)) begin failures++;
            $display("FAIL registered_fn got mask=%h count=%0d exp %h/%0d", m, n, exp_m, ref_count(exp_m)); end
        checks++; if (dc !== DONE_AT) begin failures++;
            $display("FAIL registered_latency got=%0d exp=%0d", dc, DONE_AT); end
        fut_reg_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_z_function();
        test_constants();
        test_ignore_start();
        test_reset_mid_sweep();
        test_random();
        test_back_to_back();
        test_registered_fut();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
